fifo_capture_seq: RTL and testbench
===================================

Name: fifo_capture_seq

Overview:
- Sample-clock-domain sequencer that drives the ADC capture FIFO datapath.
- Turns arm and trigger events into a gated, downsampled write strobe, a discard strobe for the pre-trigger window, and capture stop/done status.
- Owns presample and sample counting, so the FIFO bridge only moves data.
- Sits between the trigger/arm logic and the fast ADC FIFO write port.

Parameters:
CNT_W, 32, width of presample_i, samples_i and sample_count_o
DS_W, 13, width of downsample_i

Ports:
adc_sampleclk  in  1  sole clock
reset  in  1  synchronous, active-high
arm_i  in  1  level; rising edge starts a capture
trig_i  in  1  trigger level, sampled each cycle
presample_i  in  CNT_W  samples to keep before trigger
samples_i  in  CNT_W  total samples per capture (presamples included)
downsample_i  in  DS_W  cycles skipped between written samples
stream_mode  in  1  1=stream mode: no sample limit
fifo_full_i  in  1  fast FIFO full
fifo_wr_o  out  1  write strobe to fast FIFO
fifo_discard_o  out  1  pop-oldest strobe (pre-trigger window)
capture_go_o  out  1  high from trigger until stop
capture_done_o  out  1  high in DONE
overflow_o  out  1  sticky overflow flag
sample_count_o  out  CNT_W  samples written since arm
state_o  out  3  current state encoding

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies mid-capture and aborts it.
- arm_i is registered; a rising edge is detected one cycle after arm_i rises. The next cycle enters PRESAMP and clears sample_count_o, the downsample counter and overflow_o.
- A rising arm edge in any state restarts the capture at PRESAMP.
- Downsample counter:
  - Runs from 0 to downsample_i, then wraps.
  - Sample slot = counter equals downsample_i.
  - downsample_i=0 gives a slot every cycle.
  - The counter is held at 0 in IDLE and DONE.
- fifo_wr_o is registered: asserted the cycle after a qualifying slot.
- States:
  - IDLE(0): no strobes; waits for an arm edge.
  - PRESAMP(1):
    - fifo_wr_o on each slot; sample_count_o increments.
    - Exits to WAIT_TRIG when sample_count_o equals presample_i.
    - presample_i=0 passes straight to WAIT_TRIG.
    - trig_i is ignored in this state.
  - WAIT_TRIG(2):
    - If presample_i>0: each slot asserts fifo_wr_o and fifo_discard_o together, and sample_count_o holds. The window stays exactly presample_i deep.
    - If presample_i=0: no strobes.
    - trig_i=1 enters POST next cycle and sets capture_go_o.
    - A slot in the trigger cycle still writes and discards.
  - POST(3):
    - fifo_wr_o on each slot; sample_count_o increments.
    - Non-stream: enters DONE when sample_count_o reaches the effective total. The last write is the one that makes the count equal the total.
    - Effective total = max(samples_i, presample_i+1), computed in CNT_W+1 bits with no wrap.
    - Stream mode: samples_i is ignored.
  - DONE(4):
    - capture_go_o=0, capture_done_o=1, no strobes.
    - Holds until an arm edge or reset.
- fifo_full_i:
  - Any slot with fifo_full_i=1 in PRESAMP or POST suppresses the write and sets overflow_o.
  - The state then goes to DONE, in both normal and stream mode.
  - In WAIT_TRIG, full with discard is legal and does not flag overflow.
- sample_count_o saturates at all-ones and never wraps.
- Registers presample_i, samples_i, downsample_i and stream_mode are sampled once at the arm edge. Changes mid-capture have no effect.

Optional Feature:
- Macro: TRIG_HOLDOFF_EN.
- When defined:
  - Adds input trig_holdoff_i, 16 bits.
  - On entering WAIT_TRIG, a counter loads trig_holdoff_i. trig_i is ignored until the counter reaches 0.
  - Holdoff 0 means no holdoff.
  - Window writes and discards continue during holdoff.
- When undefined: port absent; trig_i is honoured on the first WAIT_TRIG cycle.

Test Plan:
- presample_i=4, samples_i=10, downsample_i=0, trigger 20 cycles after arm -> 4 writes in PRESAMP, 1:1 write+discard until the trigger, 6 post writes; capture_done_o=1; sample_count_o=10.
- downsample_i=2, presample_i=0, samples_i=3 -> fifo_wr_o every 3rd cycle after the trigger; exactly 3 writes; no discards.
- presample_i=5, samples_i=2 -> effective total 6: 5 presamples plus 1 post sample, then DONE.
- stream_mode=1, samples_i=8, fifo_full_i forced at post sample 100 -> 99 post writes; overflow_o=1; DONE; capture_go_o drops the cycle after.
- New arm edge during POST at sample 3 -> returns to PRESAMP; sample_count_o=0; overflow_o cleared. Reset during WAIT_TRIG -> IDLE, all outputs 0 next cycle.
- TRIG_HOLDOFF_EN, trig_holdoff_i=10, trig_i held high -> POST entered on exactly the 11th WAIT_TRIG cycle.

Source files
------------

// File: rtl/fifo_capture_seq_if.sv
// Bus between trigger/arm control and the ADC capture sequencer.
// Optional TRIG_HOLDOFF_EN adds the trig_holdoff_i field.
interface fifo_capture_seq_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned DS_W  = 13
);
   logic             arm_i;
   logic             trig_i;
   logic [CNT_W-1:0] presample_i;
   logic [CNT_W-1:0] samples_i;
   logic [DS_W-1:0]  downsample_i;
   logic             stream_mode;
   logic             fifo_full_i;
`ifdef TRIG_HOLDOFF_EN
   logic [15:0]      trig_holdoff_i;
`endif
   logic             fifo_wr_o;
   logic             fifo_discard_o;
   logic             capture_go_o;
   logic             capture_done_o;
   logic             overflow_o;
   logic [CNT_W-1:0] sample_count_o;
   logic [2:0]       state_o;

   modport slave (
      input  arm_i, trig_i, presample_i, samples_i, downsample_i, stream_mode, fifo_full_i,
`ifdef TRIG_HOLDOFF_EN
      input  trig_holdoff_i,
`endif
      output fifo_wr_o, fifo_discard_o, capture_go_o, capture_done_o, overflow_o,
      output sample_count_o, state_o
   );

   modport master (
      output arm_i, trig_i, presample_i, samples_i, downsample_i, stream_mode, fifo_full_i,
`ifdef TRIG_HOLDOFF_EN
      output trig_holdoff_i,
`endif
      input  fifo_wr_o, fifo_discard_o, capture_go_o, capture_done_o, overflow_o,
      input  sample_count_o, state_o
   );
endinterface

// File: rtl/fifo_capture_seq.sv
// ADC capture sequencer: arm/trigger to gated, downsampled FIFO write/discard strobes.
// Optional trigger holdoff enabled by defining TRIG_HOLDOFF_EN.
module fifo_capture_seq #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned DS_W  = 13
) (
   input logic               adc_sampleclk,
   input logic               reset,
   fifo_capture_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESAMP   = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t           state, state_n;
   logic             arm_r, arm_r2;
   logic [CNT_W-1:0] pre_cfg, smp_cfg, cnt;
   logic [DS_W-1:0]  ds_cfg, ds_cnt;
   logic             stream_cfg;
   logic             wr_q, disc_q, go_q, done_q, ovf_q;
   logic             wr_n, disc_n, inc, ovf_set;
   logic             arm_edge, active, slot, trig_ok;
   logic [CNT_W:0]   pre_p1, smp_ext, total, cnt_p1;
   logic [CNT_W-1:0] cnt_sat;

   assign arm_edge = arm_r & ~arm_r2;
   assign active   = (state == PRESAMP) || (state == WAIT_TRIG) || (state == POST);
   assign slot     = active && (ds_cnt == ds_cfg);

   // Effective total is one bit wider so presample_i+1 never wraps.
   assign pre_p1  = {1'b0, pre_cfg} + (CNT_W+1)'(1);
   assign smp_ext = {1'b0, smp_cfg};
   assign total   = (smp_ext > pre_p1) ? smp_ext : pre_p1;
   assign cnt_p1  = {1'b0, cnt} + (CNT_W+1)'(1);
   assign cnt_sat = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef TRIG_HOLDOFF_EN
   logic [15:0] hold_cnt;
   assign trig_ok = (hold_cnt == 16'd0);
`else
   assign trig_ok = 1'b1;
`endif

   always_comb begin
      state_n = state;
      wr_n    = 1'b0;
      disc_n  = 1'b0;
      inc     = 1'b0;
      ovf_set = 1'b0;
      if (arm_edge) begin
         state_n = PRESAMP;
      end else begin
         case (state)
            IDLE: ;
            PRESAMP: begin
               if (cnt == pre_cfg) begin
                  state_n = WAIT_TRIG;
               end else if (slot) begin
                  if (bus.fifo_full_i) begin
                     ovf_set = 1'b1;
                     state_n = DONE;
                  end else begin
                     wr_n = 1'b1;
                     inc  = 1'b1;
                  end
               end
            end
            WAIT_TRIG: begin
               // Window write+discard keeps the pre-trigger depth constant; full is harmless here.
               if (slot && (pre_cfg != '0)) begin
                  wr_n   = 1'b1;
                  disc_n = 1'b1;
               end
               if (trig_ok && bus.trig_i)
                  state_n = POST;
            end
            POST: begin
               if (slot) begin
                  if (bus.fifo_full_i) begin
                     ovf_set = 1'b1;
                     state_n = DONE;
                  end else begin
                     wr_n = 1'b1;
                     inc  = 1'b1;
                     if (!stream_cfg && (cnt_p1 >= total))
                        state_n = DONE;
                  end
               end
            end
            DONE: ;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge adc_sampleclk) begin
      if (reset) begin
         state      <= IDLE;
         arm_r      <= 1'b0;
         arm_r2     <= 1'b0;
         pre_cfg    <= '0;
         smp_cfg    <= '0;
         ds_cfg     <= '0;
         stream_cfg <= 1'b0;
         ds_cnt     <= '0;
         cnt        <= '0;
         wr_q       <= 1'b0;
         disc_q     <= 1'b0;
         go_q       <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         arm_r  <= bus.arm_i;
         arm_r2 <= arm_r;
         state  <= state_n;
         wr_q   <= wr_n;
         disc_q <= disc_n;
         go_q   <= (state_n == POST);
         done_q <= (state_n == DONE);
         if (arm_edge) begin
            pre_cfg    <= bus.presample_i;
            smp_cfg    <= bus.samples_i;
            ds_cfg     <= bus.downsample_i;
            stream_cfg <= bus.stream_mode;
            cnt        <= '0;
            ds_cnt     <= '0;
            ovf_q      <= 1'b0;
         end else begin
            if (inc)
               cnt <= cnt_sat;
            if (ovf_set)
               ovf_q <= 1'b1;
            if ((state_n == IDLE) || (state_n == DONE) || slot)
               ds_cnt <= '0;
            else
               ds_cnt <= ds_cnt + DS_W'(1);
         end
      end
   end

`ifdef TRIG_HOLDOFF_EN
   always_ff @(posedge adc_sampleclk) begin
      if (reset)
         hold_cnt <= 16'd0;
      else if ((state_n == WAIT_TRIG) && (state != WAIT_TRIG))
         hold_cnt <= bus.trig_holdoff_i;
      else if ((state == WAIT_TRIG) && (hold_cnt != 16'd0))
         hold_cnt <= hold_cnt - 16'd1;
   end
`endif

   assign bus.fifo_wr_o      = wr_q;
   assign bus.fifo_discard_o = disc_q;
   assign bus.capture_go_o   = go_q;
   assign bus.capture_done_o = done_q;
   assign bus.overflow_o     = ovf_q;
   assign bus.sample_count_o = cnt;
   assign bus.state_o        = state;
endmodule

// File: tb/tb_fifo_capture_seq.sv
// Directed self-checking bench for fifo_capture_seq (optional holdoff test under TRIG_HOLDOFF_EN).
module tb_fifo_capture_seq;
   logic clk = 1'b0;
   logic reset;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned wr_cnt = 0;
   int unsigned disc_cnt = 0;

   fifo_capture_seq_if #(.CNT_W(32), .DS_W(13)) bus ();
   fifo_capture_seq #(.CNT_W(32), .DS_W(13)) dut (
      .adc_sampleclk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Advance one cycle, sample 1 time unit after the edge, tally strobes.
   task automatic tick();
      @(posedge clk);
      #1;
      wr_cnt   += 32'(bus.fifo_wr_o);
      disc_cnt += 32'(bus.fifo_discard_o);
   endtask

   task automatic do_arm();
      bus.arm_i = 1'b1;
      tick();
      tick();
      bus.arm_i = 1'b0;
      wr_cnt = 0;
      disc_cnt = 0;
      n_cmp++;
      if (bus.state_o !== 3'd1) begin
         $display("FAIL arm_presamp: got %0d want 1", bus.state_o); n_bad++;
      end
   endtask

   task automatic set_cfg(input int unsigned pre, input int unsigned smp,
                          input int unsigned ds, input logic strm);
      bus.presample_i  = pre;
      bus.samples_i    = smp;
      bus.downsample_i = 13'(ds);
      bus.stream_mode  = strm;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.arm_i = 1'b0; bus.trig_i = 1'b0; bus.fifo_full_i = 1'b0;
`ifdef TRIG_HOLDOFF_EN
      bus.trig_holdoff_i = 16'd0;
`endif
      set_cfg(0, 0, 0, 1'b0);
      tick(); tick();
      n_cmp++;
      if ({bus.fifo_wr_o, bus.fifo_discard_o, bus.capture_go_o, bus.capture_done_o,
           bus.overflow_o} !== 5'b0 || bus.sample_count_o !== 32'd0 || bus.state_o !== 3'd0) begin
         $display("FAIL reset_outputs: got st=%0d cnt=%0d want all zero", bus.state_o, bus.sample_count_o);
         n_bad++;
      end
      reset = 1'b0;
      tick(); tick();
      n_cmp++;
      if (bus.state_o !== 3'd0) begin
         $display("FAIL idle_hold: got %0d want 0", bus.state_o); n_bad++;
      end
   endtask

   task automatic test_basic_capture();
      set_cfg(4, 10, 0, 1'b0);
      do_arm();
      repeat (5) tick();
      n_cmp++;
      if (bus.state_o !== 3'd2 || wr_cnt != 4) begin
         $display("FAIL basic_presamp: got st=%0d wr=%0d want st=2 wr=4", bus.state_o, wr_cnt); n_bad++;
      end
      repeat (14) tick();
      bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      n_cmp++;
      if (bus.state_o !== 3'd3 || bus.capture_go_o !== 1'b1) begin
         $display("FAIL basic_trig: got st=%0d go=%0b want st=3 go=1", bus.state_o, bus.capture_go_o); n_bad++;
      end
      n_cmp++;
      if (disc_cnt != 15 || bus.sample_count_o !== 32'd4) begin
         $display("FAIL basic_window: got disc=%0d cnt=%0d want disc=15 cnt=4", disc_cnt, bus.sample_count_o); n_bad++;
      end
      repeat (6) tick();
      n_cmp++;
      if (bus.state_o !== 3'd4 || bus.capture_done_o !== 1'b1 || bus.capture_go_o !== 1'b0) begin
         $display("FAIL basic_done: got st=%0d done=%0b go=%0b want 4/1/0", bus.state_o,
                  bus.capture_done_o, bus.capture_go_o); n_bad++;
      end
      n_cmp++;
      if (bus.sample_count_o !== 32'd10 || wr_cnt != 25) begin
         $display("FAIL basic_count: got cnt=%0d wr=%0d want cnt=10 wr=25", bus.sample_count_o, wr_cnt); n_bad++;
      end
      repeat (3) tick();
      n_cmp++;
      if (wr_cnt != 25 || disc_cnt != 15 || bus.state_o !== 3'd4) begin
         $display("FAIL basic_quiet: got wr=%0d disc=%0d st=%0d want 25/15/4", wr_cnt, disc_cnt, bus.state_o); n_bad++;
      end
   endtask

   task automatic test_downsample();
      set_cfg(0, 3, 2, 1'b0);
      do_arm();
      tick();
      n_cmp++;
      if (bus.state_o !== 3'd2 || wr_cnt != 0) begin
         $display("FAIL ds_waittrig: got st=%0d wr=%0d want st=2 wr=0", bus.state_o, wr_cnt); n_bad++;
      end
      bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_cmp++;
         if (bus.fifo_wr_o !== ((i == 1) || (i == 4) || (i == 7))) begin
            $display("FAIL ds_pattern[%0d]: got %0b want %0b", i, bus.fifo_wr_o,
                     ((i == 1) || (i == 4) || (i == 7))); n_bad++;
         end
      end
      n_cmp++;
      if (wr_cnt != 3 || disc_cnt != 0 || bus.state_o !== 3'd4 || bus.sample_count_o !== 32'd3) begin
         $display("FAIL ds_totals: got wr=%0d disc=%0d st=%0d cnt=%0d want 3/0/4/3", wr_cnt, disc_cnt,
                  bus.state_o, bus.sample_count_o); n_bad++;
      end
   endtask

   task automatic test_eff_total();
      set_cfg(5, 2, 0, 1'b0);
      do_arm();
      repeat (6) tick();
      n_cmp++;
      if (bus.state_o !== 3'd2 || wr_cnt != 5) begin
         $display("FAIL eff_presamp: got st=%0d wr=%0d want st=2 wr=5", bus.state_o, wr_cnt); n_bad++;
      end
      bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      tick();
      n_cmp++;
      if (bus.state_o !== 3'd4 || bus.sample_count_o !== 32'd6 || wr_cnt != 7 || disc_cnt != 1) begin
         $display("FAIL eff_done: got st=%0d cnt=%0d wr=%0d disc=%0d want 4/6/7/1", bus.state_o,
                  bus.sample_count_o, wr_cnt, disc_cnt); n_bad++;
      end
   endtask

   task automatic test_stream_overflow();
      set_cfg(0, 8, 0, 1'b1);
      do_arm();
      tick();
      bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      repeat (99) tick();
      n_cmp++;
      if (bus.state_o !== 3'd3 || bus.capture_go_o !== 1'b1 || wr_cnt != 99) begin
         $display("FAIL stream_run: got st=%0d go=%0b wr=%0d want 3/1/99", bus.state_o,
                  bus.capture_go_o, wr_cnt); n_bad++;
      end
      bus.fifo_full_i = 1'b1;
      tick();
      bus.fifo_full_i = 1'b0;
      n_cmp++;
      if (bus.overflow_o !== 1'b1 || bus.state_o !== 3'd4 || bus.capture_go_o !== 1'b0) begin
         $display("FAIL stream_ovf: got ovf=%0b st=%0d go=%0b want 1/4/0", bus.overflow_o,
                  bus.state_o, bus.capture_go_o); n_bad++;
      end
      n_cmp++;
      if (wr_cnt != 99 || bus.sample_count_o !== 32'd99 || bus.capture_done_o !== 1'b1) begin
         $display("FAIL stream_cnt: got wr=%0d cnt=%0d done=%0b want 99/99/1", wr_cnt,
                  bus.sample_count_o, bus.capture_done_o); n_bad++;
      end
   endtask

   task automatic test_rearm_and_reset();
      set_cfg(0, 10, 0, 1'b0);
      do_arm();
      n_cmp++;
      if (bus.overflow_o !== 1'b0 || bus.sample_count_o !== 32'd0) begin
         $display("FAIL rearm_clear: got ovf=%0b cnt=%0d want 0/0", bus.overflow_o, bus.sample_count_o); n_bad++;
      end
      tick();
      bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (bus.sample_count_o !== 32'd3 || bus.state_o !== 3'd3) begin
         $display("FAIL rearm_post3: got cnt=%0d st=%0d want 3/3", bus.sample_count_o, bus.state_o); n_bad++;
      end
      do_arm();
      n_cmp++;
      if (bus.sample_count_o !== 32'd0 || bus.fifo_wr_o !== 1'b0 || bus.capture_go_o !== 1'b0) begin
         $display("FAIL rearm_restart: got cnt=%0d wr=%0b go=%0b want 0/0/0", bus.sample_count_o,
                  bus.fifo_wr_o, bus.capture_go_o); n_bad++;
      end
      tick();
      n_cmp++;
      if (bus.state_o !== 3'd2) begin
         $display("FAIL rearm_waittrig: got %0d want 2", bus.state_o); n_bad++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if ({bus.fifo_wr_o, bus.fifo_discard_o, bus.capture_go_o, bus.capture_done_o,
           bus.overflow_o} !== 5'b0 || bus.sample_count_o !== 32'd0 || bus.state_o !== 3'd0) begin
         $display("FAIL midreset: got st=%0d cnt=%0d want all zero", bus.state_o, bus.sample_count_o); n_bad++;
      end
   endtask

`ifdef TRIG_HOLDOFF_EN
   task automatic test_holdoff();
      int unsigned k;
      set_cfg(0, 4, 0, 1'b0);
      bus.trig_holdoff_i = 16'd10;
      bus.trig_i = 1'b1;
      do_arm();
      tick();
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (bus.state_o == 3'd3) begin
            k = i;
            break;
         end
      end
      bus.trig_i = 1'b0;
      bus.trig_holdoff_i = 16'd0;
      n_cmp++;
      if (k != 11) begin
         $display("FAIL holdoff_cycles: got %0d want 11 (0 means timeout)", k); n_bad++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_capture();
      test_downsample();
      test_eff_total();
      test_stream_overflow();
      test_rearm_and_reset();
`ifdef TRIG_HOLDOFF_EN
      test_holdoff();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
